// File: rtl/mul_iter.sv
// Iterative 64-bit unsigned shift-add multiplier for the execute stage.
// Takes rd1/rd2 from the register file and returns either the low half (MUL)
// or the high half (UMULH) of the 2N-bit product. The result goes to the
// regfile write port with a single-cycle write-enable pulse. Writes to X31
// (XZR) are suppressed.
module mul_iter #(
    parameter int N  = 64,
    parameter int CW = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   wa_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   wa_out,
    output logic         we_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2*N:0]    r_p;        // {carry, upper half, lower half/multiplier}
    logic [N-1:0]    r_mcand;
    logic [CW-1:0]   r_count;
    logic            r_op;
    logic [4:0]      r_wa;
    logic            r_busy;
    logic            r_done;
    logic            r_we;
    logic [N-1:0]    r_result;

    logic [N:0]      w_upper;
    logic [2*N:0]    w_p_next;
    logic            w_last;
    logic            w_accept;

    // One shift-add step. Before the add, the top bit of P is always 0, so
    // the N+1-bit sum cannot overflow. The carry lands in bit 2N and is then
    // shifted down.
    always_comb begin
        w_upper  = r_p[2*N:N];
        if (r_p[0]) begin
            w_upper = r_p[2*N:N] + {1'b0, r_mcand};
        end
        w_p_next = {1'b0, w_upper, r_p[N-1:1]};
    end

    assign w_last   = (r_count == CW'(N - 1));
    assign w_accept = start && (r_state != S_RUN);

    // Sequencer: accept, iterate N times, then present the result for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
            r_op     <= 1'b0;
            r_wa     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // The done/we pulse lasts exactly one cycle.
                    r_done <= 1'b0;
                    r_we   <= 1'b0;
                    if (w_accept) begin
                        r_mcand <= a;
                        r_op    <= op;
                        r_wa    <= wa_in;
                        r_p     <= {{(N+1){1'b0}}, b};
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_we     <= (r_wa != 5'd31);
                        r_result <= r_op ? w_p_next[2*N-1:N] : w_p_next[N-1:0];
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign we_out = r_we;
    assign result = r_result;
    assign wa_out = r_wa;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: the driver pushes the expected response for
// every accepted operation, and the monitor pops and compares on each done pulse.
module tb_mul_iter;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   wa_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [4:0]   wa_out;
    logic         we_out;

    typedef struct {
        logic [N-1:0] res;
        logic [4:0]   wa;
        logic         we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;

    mul_iter #(.N(64), .CW(7)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .wa_in  (wa_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa_out (wa_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    // Compare one value and log it if it is wrong.
    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: the exact 128-bit product, with one half selected.
    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                   input logic mop, input logic [4:0] mwa);
        logic [2*N-1:0] prod;
        exp_t e;
        prod  = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
        e.res = mop ? prod[2*N-1:N] : prod[N-1:0];
        e.wa  = mwa;
        e.we  = (mwa != 5'd31);
        return e;
    endfunction

    // Monitor: check each done pulse against the scoreboard and the busy duration.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (we_out && !done) chk("we_without_done", 64'(we_out), 64'(done));
            if (done) begin
                exp_t e;
                $display("txn result=%h wa_out=%0d we_out=%0b busy_cycles=%0d",
                         result, wa_out, we_out, busy_run);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("wa_out", 64'(wa_out), 64'(e.wa));
                    chk("we_out", 64'(we_out), 64'(e.we));
                    chk("busy_cycles", 64'(busy_run), 64'd64);
                end
            end
            if (busy) busy_run = busy_run + 1;
            else      busy_run = 0;
        end
    end

    // Wait for a free slot, present one operation, record its expected response.
    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic top, input logic [4:0] twa);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("issue_timeout", 64'(guard), 64'd0);
        a = ta; b = tb_v; op = top; wa_in = twa; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(ta, tb_v, top, twa));
        #1 start = 1'b0;
    endtask

    // Wait until all expected responses have been seen, bounded.
    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy || done) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; wa_in = '0;
        #12;
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_we",     64'(we_out), 64'd0);
        chk("rst_result", result,      64'd0);
        chk("rst_wa",     64'(wa_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MUL basic, started on the first edge after reset is released
        a = 64'd3; b = 64'd5; op = 1'b0; wa_in = 5'd9; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(64'd3, 64'd5, 1'b0, 5'd9));
        #1 start = 1'b0;
        drain();

        // UMULH and MUL of the same operands
        issue(64'h8000_0000_0000_0000, 64'd4, 1'b1, 5'd1);
        issue(64'h8000_0000_0000_0000, 64'd4, 1'b0, 5'd2);
        // Maximum operands, exercising the carry into the top bit
        issue('1, '1, 1'b0, 5'd3);
        issue('1, '1, 1'b1, 5'd3);
        drain();

        // start while busy is ignored
        issue(64'd7, 64'd6, 1'b0, 5'd5);
        repeat (10) @(negedge clk);
        a = 64'd100; b = 64'd100; wa_in = 5'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (70) @(negedge clk);

        // Back-to-back with start held high; first op targets XZR
        @(negedge clk);
        a = 64'd2; b = 64'd10; op = 1'b0; wa_in = 5'd31; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(64'd2, 64'd10, 1'b0, 5'd31));
        #1 a = 64'd9; b = 64'd9; wa_in = 5'd4;
        begin
            int guard = 0;
            @(negedge clk);
            while (!done && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("b2b_timeout", 64'(guard), 64'd0);
        end
        @(posedge clk);
        exp_q.push_back(model(64'd9, 64'd9, 1'b0, 5'd4));
        #1 start = 1'b0;
        drain();

        // Reset 20 cycles into RUN aborts the operation
        issue(64'd12345, 64'd678, 1'b0, 5'd7);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_busy",   64'(busy),   64'd0);
        chk("mid_rst_done",   64'(done),   64'd0);
        chk("mid_rst_we",     64'(we_out), 64'd0);
        chk("mid_rst_result", result,      64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        issue(64'd11, 64'd11, 1'b0, 5'd8);
        drain();

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic [4:0]   rw;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 0) rb = '1;
            rw = (i % 7 == 3) ? 5'd31 : 5'($urandom_range(0, 30));
            issue(ra, rb, 1'($urandom_range(0, 1)), rw);
        end
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative 64-bit unsigned shift-add multiplier in the execute stage, directly downstream of the register file. It consumes the two read ports (rd1, rd2) and produces a MUL (low 64 bits) or UMULH (high 64 bits) result. It hands the result back to the register-file write port (wd3/wa3/we3) with a one-cycle write-enable pulse. While it computes, busy stalls the issuing stage.

## Interface
- N, 64: operand width; the product is 2N bits internally.
- CW, 7: iteration counter width; must satisfy 2^CW > N.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only when busy==0.
- op  in  1  0 = MUL (product bits N-1:0), 1 = UMULH (product bits 2N-1:N).
- a  in  N  multiplicand (regfile rd1).
- b  in  N  multiplier (regfile rd2).
- wa_in  in  5  destination register index.
- busy  out  1  high while an operation is iterating.
- done  out  1  one-cycle pulse when the result becomes valid.
- result  out  N  selected product half; holds until the next completion.
- wa_out  out  5  latched destination index, drives regfile wa3.
- we_out  out  1  regfile write-enable pulse; coincides with done.

## Operation
- Three states: IDLE, RUN, DONE.
- **IDLE, start==1:**
  - Latch a → mcand, op, wa_in.
  - Load P = {(N+1)'b0, b}; P is 2N+1 bits.
  - Clear count; go to RUN.
- **IDLE, start==0:** stay in IDLE.
- **RUN, each edge:**
  - If P[0]==1, add mcand into P[2N:N] (N+1-bit sum, carry kept in bit 2N).
  - Then shift P right by one (logical).
  - Increment count.
- **RUN exit:** the edge that performs iteration N (count==N-1 before the edge) moves to DONE. Latch result at the same time:
  - op==0: result = P_next[N-1:0].
  - op==1: result = P_next[2N-1:N].
- **DONE:** done=1 and we_out=(wa_out!=31) for exactly one cycle; X31 is XZR and is never written.
- **DONE, next edge:**
  - start==1: accept a new operation exactly as from IDLE, going straight to RUN (back-to-back).
  - start==0: go to IDLE.
- Arithmetic is unsigned with no overflow: the full 2N-bit product is exact.
- start while busy==1 is ignored; latched operands and the destination index do not change.
- a, b, op and wa_in may change freely after the accepting edge.

## Timing
- busy = (state==RUN). It rises the cycle after the accepting edge and falls on the edge that enters DONE.
- Latency, counted from the accepting edge (edge 0):
  - Iterations occur on edges 1..N.
  - done/we_out are high from edge N to edge N+1.
  - For N=64, the result is written on edge 65 (the regfile write edge).
- Throughput: one operation per N+1 cycles when start is held high.
- result, wa_out and done/we_out are registered outputs, with no combinational path from inputs.
- Reset values:
  - State: IDLE.
  - busy, done, we_out: 0.
  - result, wa_out: 0.
  - P, mcand, count: 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No we_out pulse is produced, even if reset deasserts in the cycle done would have risen.
- A start on the first edge after reset deasserts is accepted normally.

## Test plan
- **MUL basic:** a=3, b=5, op=0, wa_in=9, start for one cycle.
  - Required: busy high for 64 cycles.
  - Then done=we_out=1 for one cycle with result=15, wa_out=9.
- **UMULH:** a=2^63, b=4, op=1.
  - Required: result=2.
  - Repeat with op=0: result=0.
- **Max operands:** a=b=0xFFFF_FFFF_FFFF_FFFF.
  - Required: op=0 gives result=1; op=1 gives result=0xFFFF_FFFF_FFFF_FFFE.
  - Checks the carry into bit 2N.
- **Start while busy:** start a=7, b=6; then pulse start with a=100, b=100 mid-RUN.
  - Required: a single done pulse 64 cycles after the first start, with result=42.
  - No second operation is launched.
- **Back-to-back and XZR:**
  - Hold start high: first op a=2, b=10, wa_in=31; second op a=9, b=9, wa_in=4.
  - Required: first done with result=20 and we_out=0.
  - Second op accepted on the DONE edge; second done exactly 65 cycles later with result=81, we_out=1, wa_out=4.
- **Reset mid-operation:** assert reset 20 cycles into RUN.
  - Required: busy, done, we_out, result all 0 immediately, with no pulse afterward.
  - A subsequent start with a=11, b=11 yields result=121.
